tdm_demux_1to4: RTL and testbench
=================================

Name: tdm_demux_1to4

Overview:
Serial time-division demultiplexer, the receive-side counterpart of the team's 4:1 channel mux. Takes one serial bit stream carrying 4 slots per frame, aligns to a frame-sync marker, and deserializes each slot into its own parallel channel register with a per-channel valid pulse. Sits between the serial link input and the four per-channel consumers.

Parameters:
SLOT_BITS, 8, bits per slot (valid range 2..32); frame is 4*SLOT_BITS bits
MISS_LIMIT, 2, consecutive missed frame-syncs at the expected position before lock is dropped (valid range 1..7)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  1  serial data bit, MSB of each slot first
din_valid  input  1  din/frame_sync are sampled only when high
frame_sync  input  1  high coincident with bit 0 (MSB) of slot 0
y0  output  SLOT_BITS  slot 0 data, registered
y1  output  SLOT_BITS  slot 1 data, registered
y2  output  SLOT_BITS  slot 2 data, registered
y3  output  SLOT_BITS  slot 3 data, registered
y_valid  output  4  one-cycle pulse, bit k marks new data on yk
locked  output  1  high while in LOCKED state
sync_err  output  1  one-cycle pulse on sync misplacement or miss

Behaviour:
- Reset (rst high at a clock edge): y0..y3 = 0, y_valid = 0, locked = 0, sync_err = 0, bit/slot counters = 0, shift register = 0, miss counter = 0, state = HUNT. Reset wins over all other inputs; reset mid-frame discards the partial slot without a y_valid pulse.
- din_valid low: no state, counter or shift-register change; y_valid and sync_err are 0 that cycle; yk hold.
- States: HUNT, LOCKED.
- HUNT: din ignored until a valid cycle with frame_sync=1. That bit is captured as bit 0 of slot 0 and the state goes to LOCKED (locked=1 from the next cycle). No sync_err in HUNT.
- LOCKED: each valid cycle shifts din into the shift register (MSB first) and advances bit counter 0..SLOT_BITS-1. At wrap, the slot counter advances 0..3 and wraps to 0.
- Slot completion: on the valid cycle sampling the last bit of slot k, the next edge loads yk with the full slot (including that bit) and sets y_valid[k]=1 for exactly one cycle. Latency is 1 clock from the last-bit sample. Only one y_valid bit is ever high at a time.
- Expected sync position is slot 0, bit 0:
  - frame_sync=1 there: miss counter cleared.
  - frame_sync=0 there: sync_err pulse, miss counter +1, flywheel continues (bit captured as slot 0 bit 0). If the counter reaches MISS_LIMIT, go to HUNT, locked=0, and the counter clears. That bit is discarded.
  - frame_sync=1 at any other position: sync_err pulse. Immediate realign: the bit becomes slot 0 bit 0, the partial slot is discarded (no y_valid), the miss counter clears, and the state stays LOCKED.
- Simultaneous last-bit-of-slot-3 and wrap: y_valid[3] and the wrap happen in the same edge. The next valid bit is checked as the expected sync position.

Test Plan:
- SLOT_BITS=8, reset then one aligned frame A5,3C,F0,0F with sync on the first bit -> y0=A5,y1=3C,y2=F0,y3=0F; y_valid pulses 0001,0010,0100,1000, each 1 cycle after the slot's 8th bit; locked=1 from the cycle after sync.
- Same frame with din_valid deasserted for 3 cycles inside slot 1 -> identical outputs; y_valid[1] delayed by exactly 3 cycles; no sync_err.
- Two frames, second with no frame_sync -> one sync_err pulse at the expected position, locked stays 1, second-frame slots still decoded. Third frame also missing (MISS_LIMIT=2) -> second sync_err, locked=0 next cycle, no further y_valid until the next sync.
- frame_sync asserted at slot 2 bit 3 -> sync_err pulse, no y_valid[2] for the partial slot; the following 32 bits decode as a fresh frame starting at y0.
- rst asserted mid-slot 1 -> next cycle all outputs 0, locked=0; a subsequent aligned frame decodes correctly.
- Stream with no frame_sync from reset -> locked=0, y_valid=0, sync_err=0 for the whole run.

Source files
------------

// File: rtl/tdm_demux_1to4.sv
// Serial TDM demultiplexer, 1 stream -> 4 channels.
// Aligns to a frame-sync marker on slot 0 bit 0, deserializes each SLOT_BITS-wide slot
// (MSB first) into its own registered channel output and pulses the matching y_valid bit.
// A flywheel tolerates up to MISS_LIMIT-1 consecutive missing syncs before dropping lock.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous reset, active-high
//   din        - serial data bit
//   din_valid  - qualifies din and frame_sync
//   frame_sync - marks bit 0 of slot 0
//   y0..y3     - registered slot data per channel
//   y_valid    - one-cycle pulse, bit k marks new data on yk
//   locked     - high while frame alignment is held
//   sync_err   - one-cycle pulse on a misplaced or missing sync
module tdm_demux_1to4 #(
    parameter int unsigned SLOT_BITS  = 8,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [SLOT_BITS-1:0] y0,
    output logic [SLOT_BITS-1:0] y1,
    output logic [SLOT_BITS-1:0] y2,
    output logic [SLOT_BITS-1:0] y3,
    output logic [3:0]           y_valid,
    output logic                 locked,
    output logic                 sync_err
);

    localparam int unsigned BitW = $clog2(SLOT_BITS);

    typedef enum logic {
        StHunt,
        StLocked
    } state_e;

    state_e                      state_q, state_d;
    logic [BitW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]                  slot_q, slot_d;
    logic [SLOT_BITS-1:0]        shift_q, shift_d;
    logic [2:0]                  miss_q, miss_d;
    logic [3:0][SLOT_BITS-1:0]   y_q, y_d;
    logic [3:0]                  y_valid_q, y_valid_d;
    logic                        sync_err_q, sync_err_d;

    logic [SLOT_BITS-1:0]        shift_in;
    logic [2:0]                  miss_inc;
    logic                        at_sync_pos;
    logic                        last_bit;

    assign shift_in    = {shift_q[SLOT_BITS-2:0], din};
    assign miss_inc    = miss_q + 3'd1;
    assign at_sync_pos = (slot_q == 2'd0) && (bit_cnt_q == '0);
    assign last_bit    = (bit_cnt_q == BitW'(SLOT_BITS - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        slot_d     = slot_q;
        shift_d    = shift_q;
        miss_d     = miss_q;
        y_d        = y_q;
        y_valid_d  = 4'b0000;
        sync_err_d = 1'b0;

        if (din_valid) begin
            case (state_q)
                StHunt: begin
                    if (frame_sync) begin
                        // Sync bit is slot 0 bit 0 of the new frame.
                        state_d   = StLocked;
                        shift_d   = shift_in;
                        bit_cnt_d = BitW'(1);
                        slot_d    = 2'd0;
                        miss_d    = 3'd0;
                    end
                end
                StLocked: begin
                    if (at_sync_pos) begin
                        if (frame_sync) begin
                            miss_d    = 3'd0;
                            shift_d   = shift_in;
                            bit_cnt_d = BitW'(1);
                        end else begin
                            sync_err_d = 1'b1;
                            if (miss_inc >= 3'(MISS_LIMIT)) begin
                                // Lock lost: this bit is dropped and alignment restarts.
                                state_d   = StHunt;
                                miss_d    = 3'd0;
                                bit_cnt_d = '0;
                                slot_d    = 2'd0;
                            end else begin
                                // Flywheel: keep decoding at the predicted alignment.
                                miss_d    = miss_inc;
                                shift_d   = shift_in;
                                bit_cnt_d = BitW'(1);
                            end
                        end
                    end else if (frame_sync) begin
                        // Misplaced sync: realign on it, partial slot is abandoned.
                        sync_err_d = 1'b1;
                        shift_d    = shift_in;
                        bit_cnt_d  = BitW'(1);
                        slot_d     = 2'd0;
                        miss_d     = 3'd0;
                    end else begin
                        shift_d = shift_in;
                        if (last_bit) begin
                            y_d[slot_q]       = shift_in;
                            y_valid_d[slot_q] = 1'b1;
                            bit_cnt_d         = '0;
                            slot_d            = slot_q + 2'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHunt;
            bit_cnt_q  <= '0;
            slot_q     <= 2'd0;
            shift_q    <= '0;
            miss_q     <= 3'd0;
            y_q        <= '0;
            y_valid_q  <= 4'b0000;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_q     <= slot_d;
            shift_q    <= shift_d;
            miss_q     <= miss_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign y0       = y_q[0];
    assign y1       = y_q[1];
    assign y2       = y_q[2];
    assign y3       = y_q[3];
    assign y_valid  = y_valid_q;
    assign sync_err = sync_err_q;
    assign locked   = (state_q == StLocked);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed bench for tdm_demux_1to4 (SLOT_BITS=8, MISS_LIMIT=2).
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_tdm_demux_1to4;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] y_valid;
  logic       locked;
  logic       sync_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdm_demux_1to4 #(
    .SLOT_BITS (8),
    .MISS_LIMIT(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .frame_sync(frame_sync),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y_valid   (y_valid),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_y(input int k);
    case (k)
      0:       return y0;
      1:       return y1;
      2:       return y2;
      default: return y3;
    endcase
  endfunction

  task automatic step(input logic d, input logic fs, input logic v);
    din        = d;
    frame_sync = fs;
    din_valid  = v;
    @(posedge clk);
    #1;
  endtask

  // One slot, MSB first. k<0 means no y_valid is expected for this slot.
  // gap inserts 3 invalid cycles (with din/frame_sync high) after bit 3.
  task automatic send_byte(input logic [7:0] b, input logic fs, input int k,
                           input logic err, input logic lk, input logic gap);
    logic [3:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      step(b[7-i], fs && (i == 0), 1'b1);
      check("sync_err", sync_err, (i == 0) ? err : 1'b0);
      check("locked", locked, lk);
      if (i == 7 && k >= 0) begin
        exp_v = 4'b0001 << k;
        check("y_valid_slot", y_valid, exp_v);
        check("y_data", get_y(k), b);
      end else begin
        check("y_valid_idle", y_valid, 4'b0000);
      end
      if (gap && i == 3) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b1, 1'b1, 1'b0);
          check("gap_y_valid", y_valid, 4'b0000);
          check("gap_sync_err", sync_err, 1'b0);
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_y0", y0, 8'h00);
    check("rst_y3", y3, 8'h00);
    check("rst_y_valid", y_valid, 4'b0000);
    check("rst_locked", locked, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    rst = 1'b0;

    // Aligned frame acquired from hunt.
    send_byte(8'hA5, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    send_byte(8'hF0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    send_byte(8'h0F, 1'b0, 3, 1'b0, 1'b1, 1'b0);

    // Same frame, 3 stalled cycles inside slot 1.
    send_byte(8'hA5, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b0, 1, 1'b0, 1'b1, 1'b1);
    send_byte(8'hF0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    send_byte(8'h0F, 1'b0, 3, 1'b0, 1'b1, 1'b0);

    // First missing sync: flywheel keeps decoding.
    send_byte(8'h11, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    send_byte(8'h44, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    send_byte(8'h88, 1'b0, 3, 1'b0, 1'b1, 1'b0);

    // Second missing sync: lock lost, nothing decoded.
    send_byte(8'hFF, 1'b0, -1, 1'b1, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    check("held_y3_after_drop", y3, 8'h88);

    // Relock, then sync misplaced at slot 2 bit 3.
    send_byte(8'h5A, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    send_byte(8'hE7, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    send_byte(8'h18, 1'b0, 3, 1'b0, 1'b1, 1'b0);
    send_byte(8'h96, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h69, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("partial_no_valid", y_valid, 4'b0000);
    send_byte(8'hC3, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    send_byte(8'h81, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    send_byte(8'h7E, 1'b0, 3, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of slot 1, with sync/valid driven to show reset dominance.
    send_byte(8'hA5, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    check("midrst_y0", y0, 8'h00);
    check("midrst_y1", y1, 8'h00);
    check("midrst_y2", y2, 8'h00);
    check("midrst_y3", y3, 8'h00);
    check("midrst_y_valid", y_valid, 4'b0000);
    check("midrst_locked", locked, 1'b0);
    check("midrst_sync_err", sync_err, 1'b0);
    send_byte(8'h12, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h34, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    send_byte(8'h56, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    send_byte(8'h78, 1'b0, 3, 1'b0, 1'b1, 1'b0);

    // No sync ever after reset: stays in hunt.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'(i % 3 == 0), 1'b0, 1'b1);
      check("nosync_locked", locked, 1'b0);
      check("nosync_y_valid", y_valid, 4'b0000);
      check("nosync_sync_err", sync_err, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
